hex_scan_display: RTL and testbench

//  Multiplexed N-digit hexadecimal seven-segment driver; successor to the single-digit decoder.

---
 rtl/hex_scan_display.sv | 139 +++++++++++++
 tb/tb_hex_scan_display.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
// Multiplexed N-digit hex seven-segment driver with frame-synchronous commit,
// anode blanking gap, leading-zero suppression and per-digit decimal points.
module hex_scan_display #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   disp, pend;
    logic [DIGITS-1:0]     disp_dp, pend_dp;
    logic                  pend_v;

    logic                  slot_end, commit;
    logic [3:0]            nib;
    logic                  sel_dp, sel_blank;
    logic [DIGITS:0]       zero_run;
    logic [DIGITS-1:0]     an_hot;
    logic [6:0]            seg_al;
    logic                  dp_lit;

    // Segment codes in active-low form, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign slot_end = (cnt == CNT_LAST);
    assign commit   = slot_end && (idx == IDX_LAST);

    always_comb begin
        nib       = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        an_hot    = '0;
        zero_run  = '0;
        zero_run[DIGITS] = 1'b1;
        // zero_run[i] is set when nibble i and every nibble above it are zero.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run[i] = zero_run[i+1] && (disp[4*i +: 4] == 4'h0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = disp[4*i +: 4];
                sel_dp    = disp_dp[i];
                sel_blank = blank_lz && (i > 0) && zero_run[i];
                an_hot[i] = 1'b1;
            end
        end
        if (cnt < BLANK_END) begin
            seg_al = 7'h7F;
            dp_lit = 1'b0;
            an_hot = '0;
        end else begin
            seg_al = sel_blank ? 7'h7F : hex_to_seg(nib);
            dp_lit = sel_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            disp_dp    <= '0;
            pend       <= '0;
            pend_dp    <= '0;
            pend_v     <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            frame_tick <= commit;
            // A load landing on the commit cycle goes straight to the display.
            if (commit) begin
                if (load) begin
                    disp    <= value;
                    disp_dp <= dp_mask;
                end else if (pend_v) begin
                    disp    <= pend;
                    disp_dp <= pend_dp;
                end
                pend_v <= 1'b0;
            end else if (load) begin
                pend    <= value;
                pend_dp <= dp_mask;
                pend_v  <= 1'b1;
            end
            seg <= (ACTIVE_LOW != 0) ? seg_al : ~seg_al;
            dp  <= (ACTIVE_LOW != 0) ? ~dp_lit : dp_lit;
            an  <= (ACTIVE_LOW != 0) ? ~an_hot : an_hot;
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display: frame-position reference model, per-cycle output checks.
module tb_hex_scan_display;

    localparam int DIGITS    = 4;
    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    hex_scan_display #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
        .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference state: position within the frame plus shown/pending contents.
    int          s = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    logic [3:0]  m_dp = '0, m_pend_dp = '0;
    bit          m_pv = 0;

    logic [12:0] exp_o, obs_o;
    int tests = 0;
    int fails = 0;

    task automatic step(input bit r, input bit ld, input logic [15:0] v, input logic [3:0] d);
        int cm, dig;
        logic [15:0] upper;
        logic [6:0] es;
        logic [3:0] ea;
        logic edp;
        rst = r; load = ld; value = v; dp_mask = d;
        cm  = s % CLK_DIV;
        dig = s / CLK_DIV;
        if (r) begin
            exp_o = {7'h7F, 1'b1, 4'hF, 1'b0};
            s = 0; m_disp = '0; m_dp = '0; m_pv = 0;
        end else begin
            if (cm < BLANK_CYC) begin
                es = 7'h7F; edp = 1'b1; ea = 4'hF;
            end else begin
                upper = m_disp >> (4 * dig);
                es  = (blank_lz && dig > 0 && upper == 16'h0) ? 7'h7F : seg_tab[upper[3:0]];
                edp = ~m_dp[dig];
                ea  = ~(4'b0001 << dig);
            end
            exp_o = {es, edp, ea, (s == FRAME - 1)};
            if (s == FRAME - 1) begin
                if (ld) begin m_disp = v; m_dp = d; end
                else if (m_pv) begin m_disp = m_pend; m_dp = m_pend_dp; end
                m_pv = 0;
            end else if (ld) begin
                m_pend = v; m_pend_dp = d; m_pv = 1;
            end
            s = (s + 1) % FRAME;
        end
        @(posedge clk);
        #1;
        obs_o = {seg, dp, an, frame_tick};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 16'h0, 4'h0);
            tests++;
            if (obs_o !== exp_o) begin
                fails++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs_o, exp_o);
            end
        end
    endtask

    task automatic test_first_tick();
        int first = -1;
        for (int k = 1; k <= 40; k++) begin
            step(0, 0, 16'h0, 4'h0);
            tests++;
            if (obs_o !== exp_o) begin
                fails++;
                $display("FAIL first_frame cyc=%0d got=%h exp=%h", k, obs_o, exp_o);
            end
            if (frame_tick === 1'b1 && first < 0) first = k;
        end
        tests++;
        if (first !== 32) begin
            fails++;
            $display("FAIL first_tick_latency got=%0d exp=32", first);
        end
    endtask

    task automatic test_load_frames(input string name, input logic [15:0] v, input logic [3:0] d);
        step(0, 1, v, d);
        tests++;
        if (obs_o !== exp_o) begin
            fails++;
            $display("FAIL %s load cyc got=%h exp=%h", name, obs_o, exp_o);
        end
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(0, 0, 16'h0, 4'h0);
            tests++;
            if (obs_o !== exp_o) begin
                fails++;
                $display("FAIL %s val=%h cyc=%0d got=%h exp=%h", name, v, k, obs_o, exp_o);
            end
        end
    endtask

    task automatic test_decode();
        blank_lz = 0;
        test_load_frames("decode", 16'h12AF, 4'h0);
        test_load_frames("decode", 16'h3456, 4'h0);
        test_load_frames("decode", 16'h789B, 4'h0);
        test_load_frames("decode", 16'hCDE0, 4'h0);
    endtask

    task automatic test_leading_zero();
        blank_lz = 1;
        test_load_frames("lz", 16'h0005, 4'h0);
        test_load_frames("lz", 16'h0000, 4'h0);
        test_load_frames("lz", 16'h0500, 4'h0);
        test_load_frames("lz_dp", 16'h0000, 4'b1000);
        blank_lz = 0;
    endtask

    task automatic test_dp();
        test_load_frames("dp", 16'h89AB, 4'b0100);
        test_load_frames("dp", 16'h0101, 4'b1011);
    endtask

    task automatic test_back_to_back();
        int guard;
        guard = 0;
        while (s != 10 && guard < 2 * FRAME) begin
            step(0, 0, 16'h0, 4'h0); guard++;
        end
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k == 0) step(0, 1, 16'h1111, 4'h0);
            else if (k == 3) step(0, 1, 16'h2222, 4'h0);
            else step(0, 0, 16'h0, 4'h0);
            tests++;
            if (obs_o !== exp_o) begin
                fails++;
                $display("FAIL multi_load cyc=%0d got=%h exp=%h", k, obs_o, exp_o);
            end
        end
        guard = 0;
        while (s != FRAME - 1 && guard < 2 * FRAME) begin
            step(0, 0, 16'h0, 4'h0); guard++;
        end
        tests++;
        if (s != FRAME - 1) begin
            fails++;
            $display("FAIL commit_align got=%0d exp=%0d", s, FRAME - 1);
        end
        for (int k = 0; k < FRAME + 4; k++) begin
            if (k == 0) step(0, 1, 16'hC3D9, 4'b1010);
            else step(0, 0, 16'h0, 4'h0);
            tests++;
            if (obs_o !== exp_o) begin
                fails++;
                $display("FAIL commit_load cyc=%0d got=%h exp=%h", k, obs_o, exp_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (s != 18 && guard < 2 * FRAME) begin
            step(0, 0, 16'h0, 4'h0); guard++;
        end
        step(0, 1, 16'hF0F0, 4'hF);
        step(0, 0, 16'h0, 4'h0);
        step(0, 0, 16'h0, 4'h0);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k == 0) step(1, 0, 16'h0, 4'h0);
            else step(0, 0, 16'h0, 4'h0);
            tests++;
            if (obs_o !== exp_o) begin
                fails++;
                $display("FAIL reset_mid cyc=%0d got=%h exp=%h", k, obs_o, exp_o);
            end
        end
    endtask

    task automatic test_random();
        bit ld, r;
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            ld = ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 399) == 0);
            step(r, ld, 16'($urandom), 4'($urandom));
            tests++;
            if (obs_o !== exp_o) begin
                fails++;
                $display("FAIL random cyc=%0d got=%h exp=%h", k, obs_o, exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_decode();
        test_leading_zero();
        test_dp();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
